// File: rtl/up_counter_if.sv
// up_counter_if: control inputs and count/status outputs of up_counter
interface up_counter_if #(parameter int WIDTH = 4);
  logic             en;
  logic             ld;
  logic [WIDTH-1:0] ldvalue;
  logic [WIDTH-1:0] modval;
  logic [WIDTH-1:0] dout;
  logic             tc;
  logic             ovf;
  modport master (output en, ld, ldvalue, modval, input dout, tc, ovf);
  modport slave  (input en, ld, ldvalue, modval, output dout, tc, ovf);
endinterface

// File: rtl/up_counter.sv
// up_counter: loadable modulo up counter with terminal-count and wrap flags; define UP_COUNTER_SATURATE_EN to saturate at modval instead of wrapping
module up_counter #(parameter int WIDTH = 4) (
  input logic         clk,
  input logic         rst,
  up_counter_if.slave bus
);
  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             w_at_top;
  logic             w_wrap;
  logic [WIDTH-1:0] w_next;
  // at or above the terminal count, which also covers counts loaded or left above a lowered modval
  assign w_at_top = r_count >= bus.modval;
`ifdef UP_COUNTER_SATURATE_EN
  assign w_wrap = 1'b0;
  assign w_next = w_at_top ? bus.modval : r_count + 1'b1;
`else
  assign w_wrap = bus.en && !bus.ld && w_at_top;
  assign w_next = w_at_top ? '0 : r_count + 1'b1;
`endif
  // count register and wrap pulse: rst beats ld beats en beats hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= bus.ld ? bus.ldvalue : bus.en ? w_next : r_count;
      r_ovf   <= w_wrap;
    end
  end
  assign bus.dout = r_count;
  assign bus.tc   = r_count == bus.modval;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_up_counter;
  localparam int W = 4;
`ifdef UP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {int id; logic [W-1:0] d; logic tc; logic ovf;} exp_t;
  exp_t q[$];
  exp_t e;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int vid = 0;
  up_counter_if #(.WIDTH(W)) bus();
  up_counter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic l, input logic en, input logic [W-1:0] lv,
                      input logic [W-1:0] m, input logic [W-1:0] d, input logic o);
    @(negedge clk);
    #1;
    rst = r;
    bus.ld = l;
    bus.en = en;
    bus.ldvalue = lv;
    bus.modval = m;
    @(posedge clk);
    q.push_back('{vid, d, d == m, o});
    vid++;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 3;
      if (bus.dout !== e.d) begin
        errors++;
        $display("FAIL v%0d dout got %0d want %0d", e.id, bus.dout, e.d);
      end
      if (bus.tc !== e.tc) begin
        errors++;
        $display("FAIL v%0d tc got %b want %b", e.id, bus.tc, e.tc);
      end
      if (bus.ovf !== e.ovf) begin
        errors++;
        $display("FAIL v%0d ovf got %b want %b", e.id, bus.ovf, e.ovf);
      end
    end
  end
  initial begin
    bus.en = 1'b0;
    bus.ld = 1'b0;
    bus.ldvalue = '0;
    bus.modval = '0;
    step(1, 0, 0, 0, 5, 0, 0);
    repeat (3) step(0, 0, 0, 0, 5, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, 5, W'(i), 0);
    step(0, 0, 1, 0, 5, SAT ? 4'd5 : 4'd0, SAT ? 1'b0 : 1'b1);
    step(0, 0, 1, 0, 5, SAT ? 4'd5 : 4'd1, 0);
    step(0, 1, 0, 3, 12, 3, 0);
    step(0, 1, 1, 9, 12, 9, 0);
    step(0, 1, 0, 14, 12, 14, 0);
    step(0, 1, 1, 14, 12, 14, 0);
    step(0, 0, 1, 0, 12, SAT ? 4'd12 : 4'd0, SAT ? 1'b0 : 1'b1);
    step(0, 0, 1, 0, 12, SAT ? 4'd12 : 4'd1, 0);
    step(0, 1, 0, 14, 15, 14, 0);
    step(0, 0, 1, 0, 15, 15, 0);
    step(0, 0, 1, 0, 15, SAT ? 4'd15 : 4'd0, SAT ? 1'b0 : 1'b1);
    step(0, 0, 1, 0, 15, SAT ? 4'd15 : 4'd1, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0, SAT ? 1'b0 : 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 2, 1, 0);
    step(0, 0, 1, 0, 2, 2, 0);
    step(1, 0, 1, 0, 2, 0, 0);
    step(0, 0, 1, 0, 2, 1, 0);
    step(0, 0, 0, 0, 2, 1, 0);
    step(1, 1, 1, 7, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, SAT ? 1'b0 : 1'b1);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 5, W'(i + 1), 0);
    step(0, 0, 1, 0, 5, SAT ? 4'd5 : 4'd0, SAT ? 1'b0 : 1'b1);
    step(0, 0, 1, 0, 5, SAT ? 4'd5 : 4'd1, 0);
    step(0, 0, 1, 0, 5, SAT ? 4'd5 : 4'd2, 0);
    step(0, 1, 0, 9, 5, 9, 0);
    step(0, 0, 1, 0, 5, SAT ? 4'd5 : 4'd0, SAT ? 1'b0 : 1'b1);
    step(0, 0, 0, 0, 5, SAT ? 4'd5 : 4'd0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/up_counter.md
UP_COUNTER -- requirements
Module: up_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1: reset, synchronous and active-high.
REQ-004 Port en  input  1: count enable; increment when high.
REQ-005 Port ld  input  1: synchronous load strobe.
REQ-006 Port ldvalue  input  WIDTH: value captured into the count on ld.
REQ-007 Port modval  input  WIDTH: terminal (maximum) count; sampled every cycle, may change at any time.
REQ-008 Port dout  output  WIDTH: current count, driven directly from the count register.
REQ-009 Port tc  output  1: terminal-count flag, combinational, high while dout == modval.
REQ-010 Port ovf  output  1: registered wrap pulse, high for exactly one cycle after a wrap.

Function
REQ-011 Per-edge priority SHALL be rst > ld > en > hold.
REQ-012 ld=1 SHALL load dout <= ldvalue, regardless of en.
  - ldvalue is loaded unmodified even when it exceeds modval.
REQ-013 ld=0, en=1, dout < modval SHALL give dout <= dout + 1.
REQ-014 ld=0, en=1, dout >= modval SHALL give dout <= 0 (wrap); this includes dout above modval after a load or a modval change.
REQ-015 ld=0, en=0 SHALL hold dout unchanged.
REQ-016 ovf SHALL be 1 in the cycle after a wrap edge (REQ-014), else 0.
  - A load on the same edge suppresses the wrap and ovf.
  - Back-to-back wraps (modval=0, en=1 continuous) SHALL hold ovf=1 continuously.
REQ-017 modval=all-ones SHALL give plain modulo-2^WIDTH counting, wrapping from all-ones to 0 with an ovf pulse.
REQ-018 Increment arithmetic SHALL be WIDTH bits wide; no carry beyond WIDTH is kept.
REQ-019 Latency SHALL be 1 clock from ld/en to dout; tc SHALL follow dout and modval with zero latency.
REQ-020 No X on dout, tc or ovf once rst has been applied for at least one edge.

Reset
REQ-021 rst=1 at a rising edge SHALL set dout=0 and ovf=0, overriding ld and en.
REQ-022 After reset, tc=1 if and only if modval==0.
REQ-023 Reset asserted mid-count SHALL discard any pending wrap; ovf SHALL be 0 in the following cycle.
REQ-024 Release of rst SHALL take effect at the next edge; counting resumes from 0 with no extra idle cycle.

Configuration
REQ-025 Macro UP_COUNTER_SATURATE_EN SHALL select saturation mode when defined.
REQ-026 With UP_COUNTER_SATURATE_EN defined:
  - en=1 with dout >= modval SHALL set dout <= modval (saturate, no wrap).
  - ovf SHALL be tied to 0.
  - ld behaviour is unchanged.
REQ-027 With UP_COUNTER_SATURATE_EN undefined, REQ-014 and REQ-016 apply; port list is identical in both builds.

Verification
REQ-028 Reset/hold: rst=1 one edge, modval=5 -> dout=0, ovf=0, tc=0; en=0 for 3 edges -> dout stays 0.
REQ-029 Wrap: modval=5, en=1 from dout=0 for 7 edges -> dout 1,2,3,4,5,0,1; tc=1 only while dout=5; ovf=1 only in the cycle dout=0.
REQ-030 Load priority: dout=3, en=1, ld=1, ldvalue=9, modval=12 -> dout=9 next edge, ovf=0; ldvalue=14 with modval=12, then en=1 -> dout=0, ovf=1.
REQ-031 Full range: WIDTH=4, modval=15, en=1 -> dout 15 then 0 with ovf pulse; modval=0 continuous en -> dout=0, ovf held 1.
REQ-032 Reset mid-operation: modval=2, dout=2, en=1, rst=1 same edge -> dout=0, ovf=0.
REQ-033 Saturate build (UP_COUNTER_SATURATE_EN): modval=5, en=1 for 8 edges from 0 -> dout stops at 5, ovf never 1; ldvalue=9 then en -> dout=5.
